ahbl_gpio_port: RTL

- AHB-Lite slave GPIO port; one instance per port select line (GP_A/B/C) from the GPIO address splitter.
- Consumes the splitter's per-port select as HSEL; returns HREADYOUT/HRDATA to the splitter's response mux.
- Provides output data, per-bit direction, synchronised input sampling, and edge-triggered masked interrupts.

---
 rtl/ahbl_gpio_port_if.sv | 22 ++
 rtl/ahbl_gpio_port.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ahbl_gpio_port_if.sv
// AHB-Lite bus bundle between the GPIO address splitter and one GPIO port slave.
interface ahbl_gpio_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahbl_gpio_port.sv
// AHB-Lite GPIO port: data out, direction, synchronised inputs, edge interrupts.
// Optional atomic SET/CLR registers at 0x18/0x1C when GPIO_ATOMIC_SETCLR_EN is defined.
module ahbl_gpio_port #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahbl_gpio_port_if.slave  bus,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [2:0] OFS_DATAIN  = 3'd0;
  localparam logic [2:0] OFS_DATAOUT = 3'd1;
  localparam logic [2:0] OFS_DIR     = 3'd2;
  localparam logic [2:0] OFS_IM      = 3'd3;
  localparam logic [2:0] OFS_POL     = 3'd4;
  localparam logic [2:0] OFS_IS      = 3'd5;
`ifdef GPIO_ATOMIC_SETCLR_EN
  localparam logic [2:0] OFS_SET     = 3'd6;
  localparam logic [2:0] OFS_CLR     = 3'd7;
`endif

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic             accept;
  logic             commit;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [2:0]       addr_q, addr_d;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] im_q, im_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] is_q, is_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] evt;
  logic             irq_q, irq_d;
  logic [31:0]      rdata;

  logic unused_bus;
  assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign commit = wr_q & bus.HREADY;
  assign wdata  = bus.HWDATA[WIDTH-1:0];

  // Phase registers hold through a stalled (HREADY=0) data phase.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    if (bus.HREADY) begin
      wr_d = accept & bus.HWRITE;
      rd_d = accept & ~bus.HWRITE;
      if (accept) begin
        addr_d = bus.HADDR[4:2];
      end
    end
  end

  assign evt = (pol_q & s2_q & ~s3_q) | (~pol_q & ~s2_q & s3_q);

  // A new event is OR-ed in after the W1C mask so a coinciding set wins.
  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    im_d   = im_q;
    pol_d  = pol_q;
    is_d   = is_q | evt;
    if (commit) begin
      case (addr_q)
        OFS_DATAOUT: dout_d = wdata;
        OFS_DIR:     dir_d  = wdata;
        OFS_IM:      im_d   = wdata;
        OFS_POL:     pol_d  = wdata;
        OFS_IS:      is_d   = (is_q & ~wdata) | evt;
`ifdef GPIO_ATOMIC_SETCLR_EN
        OFS_SET:     dout_d = dout_q | wdata;
        OFS_CLR:     dout_d = dout_q & ~wdata;
`endif
        default:     ;
      endcase
    end
    irq_d = |(is_q & im_q);
  end

  always_comb begin
    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        OFS_DATAIN:  rdata = zext(s2_q);
        OFS_DATAOUT: rdata = zext(dout_q);
        OFS_DIR:     rdata = zext(dir_q);
        OFS_IM:      rdata = zext(im_q);
        OFS_POL:     rdata = zext(pol_q);
        OFS_IS:      rdata = zext(is_q);
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      dir_q  <= '0;
      im_q   <= '0;
      pol_q  <= '0;
      is_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      dir_q  <= dir_d;
      im_q   <= im_d;
      pol_q  <= pol_d;
      is_q   <= is_d;
      s1_q   <= GPIO_IN;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      irq_q  <= irq_d;
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRDATA    = rdata;
  assign GPIO_OUT      = dout_q;
  assign GPIO_OE       = dir_q;
  assign IRQ           = irq_q;

endmodule
